// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types and constants for the echo initiator
package echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TX     = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } echo_state_t;

  localparam int          ETH_HDR_LEN      = 14;
  localparam logic [15:0] ECHO_ETYPE       = 16'h1234;
  localparam logic [47:0] DEFAULT_MY_MAC   = 48'hb827eba43073;
  localparam logic [47:0] DEFAULT_PEER_MAC = 48'hffffffffffff;

  // Frame byte index width: covers 14 + 1500 bytes
  localparam int          IDX_W            = 11;

  // Byte k (0 = most significant) of a MAC address
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    logic [47:0] sh;
    sh = mac << {k, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/echo_pattern_gen.sv
// rtl/echo_pattern_gen.sv - expected echo frame byte for a given index and sequence number
module echo_pattern_gen
  import echo_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      seq,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  output logic [7:0]       byte_out
);

  logic [IDX_W-1:0] pay_i;

  assign pay_i = idx - IDX_W'(ETH_HDR_LEN);

  // Header fields first, then the sequence-seeded payload ramp
  always_comb begin
    byte_out = 8'h00;
    if (idx < IDX_W'(6)) begin
      byte_out = mac_byte(dst_mac, idx[2:0]);
    end else if (idx < IDX_W'(12)) begin
      byte_out = mac_byte(src_mac, 3'(idx - IDX_W'(6)));
    end else if (idx == IDX_W'(12)) begin
      byte_out = ECHO_ETYPE[15:8];
    end else if (idx == IDX_W'(13)) begin
      byte_out = ECHO_ETYPE[7:0];
    end else if (pay_i == IDX_W'(0)) begin
      byte_out = seq[15:8];
    end else if (pay_i == IDX_W'(1)) begin
      byte_out = seq[7:0];
    end else begin
      byte_out = seq[7:0] + pay_i[7:0];
    end
  end

endmodule

// File: rtl/echo_initiator.sv
// rtl/echo_initiator.sv - sends one echo request frame per start and waits for its reply
// Optional ok/timeout statistics counters: define ECHO_INIT_STATS_EN.
module echo_initiator
  import echo_pkg::*;
#(
  parameter int          PAYLOAD_LEN    = 46,
  parameter int          TIMEOUT_CYCLES = 500000,
  parameter logic [47:0] MY_MAC         = DEFAULT_MY_MAC,
  parameter logic [47:0] PEER_MAC       = DEFAULT_PEER_MAC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  output logic [15:0] seq,
  output logic [15:0] ok_count,
  output logic [15:0] timeout_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ETH_HDR_LEN + PAYLOAD_LEN - 1);
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  echo_state_t      state, state_nx;
  logic [IDX_W-1:0] tx_idx;
  logic [15:0]      seq_r;
  logic [31:0]      tmo_cnt;
  logic             pass_r;
  logic [7:0]       tx_exp, rx_exp;
  logic             tx_final, tmo_hit;

  logic [IDX_W-1:0] rx_idx;
  logic             rx_in_frame, rx_bad, rx_drop;
  logic [IDX_W-1:0] rx_cur_idx;
  logic             rx_cur_bad, rx_cur_drop, rx_match;

  echo_pattern_gen u_tx_gen (
    .idx      (tx_idx),
    .seq      (seq_r),
    .dst_mac  (PEER_MAC),
    .src_mac  (MY_MAC),
    .byte_out (tx_exp)
  );

  // Replies come back addressed to us; their source bytes are never compared
  echo_pattern_gen u_rx_gen (
    .idx      (rx_cur_idx),
    .seq      (seq_r),
    .dst_mac  (MY_MAC),
    .src_mac  (PEER_MAC),
    .byte_out (rx_exp)
  );

  assign tx_final = (tx_idx == LAST_IDX);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign seq      = seq_r;

  // Per-byte receive check; a frame is tainted if any byte arrives outside WAIT
  always_comb begin
    rx_cur_idx  = rx_in_frame ? rx_idx : '0;
    rx_cur_drop = (rx_in_frame & rx_drop) | (state != ST_WAIT);
    rx_cur_bad  = (rx_in_frame & rx_bad) | (rx_cur_idx > LAST_IDX);
    if (!(rx_cur_idx >= IDX_W'(6) && rx_cur_idx < IDX_W'(12)) && (rx_data != rx_exp)) begin
      rx_cur_bad = 1'b1;
    end
    rx_match = rx_valid & rx_last & ~rx_cur_drop & ~rx_cur_bad & (rx_cur_idx == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and stream/handshake outputs
  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    done     = 1'b0;
    pass     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_TX;
      end
      ST_TX: begin
        tx_valid = 1'b1;
        tx_data  = tx_exp;
        tx_last  = tx_final;
        if (tx_ready && tx_final) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (rx_match || tmo_hit) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        done     = 1'b1;
        pass     = pass_r;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Transmit index, reply timer, verdict and sequence number
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_idx  <= '0;
      tmo_cnt <= '0;
      pass_r  <= 1'b0;
      seq_r   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        tx_idx <= '0;
      end else if (state == ST_TX && tx_ready && !tx_final) begin
        tx_idx <= tx_idx + IDX_W'(1);
      end
      tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + 32'd1 : 32'd0;
      if (state == ST_WAIT) pass_r <= rx_match;
      if (state == ST_REPORT) seq_r <= seq_r + 16'd1;
    end
  end

  // Receive frame tracking across beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_idx      <= '0;
      rx_in_frame <= 1'b0;
      rx_bad      <= 1'b0;
      rx_drop     <= 1'b0;
    end else if (rx_valid) begin
      if (rx_last) begin
        rx_in_frame <= 1'b0;
      end else begin
        rx_in_frame <= 1'b1;
        rx_bad      <= rx_cur_bad;
        rx_drop     <= rx_cur_drop;
        if (rx_cur_idx != '1) rx_idx <= rx_cur_idx + IDX_W'(1);
      end
    end
  end

`ifdef ECHO_INIT_STATS_EN
  logic [15:0] ok_cnt_r, tmo_cnt_r;

  // Saturating result counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ok_cnt_r  <= '0;
      tmo_cnt_r <= '0;
    end else if (state == ST_REPORT) begin
      if (pass_r && ok_cnt_r != 16'hffff) ok_cnt_r <= ok_cnt_r + 16'd1;
      if (!pass_r && tmo_cnt_r != 16'hffff) tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  assign ok_count      = ok_cnt_r;
  assign timeout_count = tmo_cnt_r;
`else
  assign ok_count      = 16'h0000;
  assign timeout_count = 16'h0000;
`endif

endmodule

// File: doc/echo_initiator.md
ECHO_INITIATOR -- requirements
Module: echo_initiator

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 46, payload bytes per request (range 2..1500).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000, reply wait limit in clk cycles (10 ms at 50 MHz).
REQ-003 SHALL have parameter MY_MAC, default 48'hb827eba43073, source address sent.
REQ-004 SHALL have parameter PEER_MAC, default 48'hffffffffffff, destination address sent.
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port rstn  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have ports start in 1, one-cycle request pulse; busy out 1; done out 1, one-cycle result pulse; pass out 1, result valid with done.
REQ-008 SHALL have ports tx_valid out 1, tx_data out 8, tx_last out 1, tx_ready in 1: byte stream toward the MAC transmit side.
REQ-009 SHALL have ports rx_valid in 1, rx_data in 8, rx_last in 1: byte stream from the MAC receive side, no backpressure.
REQ-010 SHALL have ports seq out 16, ok_count out 16, timeout_count out 16.

Function
REQ-011 SHALL use states IDLE, TX, WAIT, REPORT; IDLE->TX on start; TX->WAIT after the tx_last byte handshake; WAIT->REPORT on a matching reply or timeout; REPORT->IDLE after one cycle.
REQ-012 SHALL transmit frame bytes 0-5 PEER_MAC, 6-11 MY_MAC (MSB first), 12-13 8'h12 8'h34, then PAYLOAD_LEN payload bytes; total 14+PAYLOAD_LEN.
REQ-013 SHALL set payload byte 0 = seq[15:8], byte 1 = seq[7:0], byte i>=2 = (seq[7:0]+i) mod 256.
REQ-014 SHALL assert tx_valid the cycle after start is accepted; hold tx_data/tx_last stable while tx_valid && !tx_ready; advance one byte per handshake cycle; tx_last only on the final byte.
REQ-015 SHALL start the timeout counter at 0 on WAIT entry and increment it every WAIT cycle.
REQ-016 SHALL compare each received frame on the fly: bytes 0-5 == MY_MAC, bytes 12-13 == 12 34, payload == REQ-013 pattern for current seq, source bytes ignored.
REQ-017 SHALL declare a match when rx_last arrives on byte index 13+PAYLOAD_LEN with no mismatch; shorter, longer or mismatching frames SHALL be discarded silently and waiting SHALL continue.
REQ-018 SHALL discard any receive frame whose first byte arrived outside WAIT, up to and including its rx_last.
REQ-019 SHALL ignore rx traffic in IDLE, TX, REPORT.
REQ-020 SHALL, in REPORT, pulse done with pass=1 (match) or pass=0 (counter reached TIMEOUT_CYCLES); on a matching rx_last in the same cycle the timeout expires, match wins.
REQ-021 SHALL increment seq (wrapping 16'hffff->0) in REPORT regardless of pass.
REQ-022 SHALL ignore start while busy; busy=1 in TX, WAIT, REPORT.
REQ-023 SHALL keep ok_count and timeout_count saturating at 16'hffff.

Reset
REQ-024 SHALL, on rstn low, asynchronously force IDLE; tx_valid, tx_last, busy, done, pass = 0; tx_data = 0; seq, ok_count, timeout_count = 0.
REQ-025 SHALL abandon a frame mid-transmit on reset without emitting tx_last; after release, the first start SHALL send seq 0.

Configuration
REQ-026 SHALL, with ECHO_INIT_STATS_EN defined, implement ok_count and timeout_count per REQ-023; without it, both ports SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-027 SHALL take from package echo_pkg: state enum, ETH_HDR_LEN=14, ECHO_ETYPE=16'h1234, default MAC constants.
REQ-028 SHALL use one combinational sub-module echo_pattern_gen (index, seq, macs -> expected byte), instantiated once for TX and once for RX comparison.

Verification (PAYLOAD_LEN=46, TIMEOUT_CYCLES=1000)
REQ-029 SHALL check: start, tx_ready=1 -> 60 bytes, bytes 12-15 = 12 34 00 00, byte 59 = 2D with tx_last.
REQ-030 SHALL check: loopback of the sent frame with bytes 0-5/6-11 swapped -> done, pass=1, seq=1, ok_count=1.
REQ-031 SHALL check: no reply -> done, pass=0 exactly 1000 WAIT cycles after entry, timeout_count=1.
REQ-032 SHALL check: reply with byte 20 corrupted, then correct reply -> first ignored, pass=1 after second.
REQ-033 SHALL check: tx_ready toggled randomly 50% -> byte sequence unchanged, no byte dropped or duplicated.
REQ-034 SHALL check: rstn low during byte 30 of TX -> all outputs 0 immediately; next start sends seq 0.
